// File: rtl/dec_scan_ctrl.sv
// 3-to-8 decoder scan sequencer: drives each enabled line for dwell+1 cycles with a 1-cycle blank between lines.
// All outputs registered; start-to-enable latency 1 cycle; stop aborts a scan and wins over start.
module dec_scan_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       single,
  input  logic [7:0] dwell,
  input  logic [7:0] mask,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       in,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, DRIVE, BLANK} state_t;

  state_t     state, state_nxt;
  logic [7:0] mask_q, mask_nxt;
  logic [7:0] dwell_q, dwell_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       single_q, single_nxt;
  logic [2:0] line, line_nxt;
  logic       in_nxt, busy_nxt, done_nxt;
  logic [2:0] first_set, above_set;
  logic       has_above;

  function automatic logic [2:0] lowest(input logic [7:0] m);
    lowest = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) lowest = 3'(i);
    end
  endfunction

  // Lowest enabled line strictly above the current one; wrap target is the lowest overall.
  always_comb begin
    first_set = lowest(mask_q);
    above_set = 3'd0;
    has_above = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(line))) begin
        above_set = 3'(i);
        has_above = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mask_q   <= 8'd0;
      dwell_q  <= 8'd0;
      single_q <= 1'b0;
      cnt      <= 8'd0;
      line     <= 3'd0;
      in       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      mask_q   <= mask_nxt;
      dwell_q  <= dwell_nxt;
      single_q <= single_nxt;
      cnt      <= cnt_nxt;
      line     <= line_nxt;
      in       <= in_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    mask_nxt   = mask_q;
    dwell_nxt  = dwell_q;
    single_nxt = single_q;
    cnt_nxt    = cnt;
    line_nxt   = line;
    case (state)
      IDLE: begin
        if (start && !stop && (mask != 8'd0)) begin
          state_nxt  = DRIVE;
          mask_nxt   = mask;
          dwell_nxt  = dwell;
          single_nxt = single;
          cnt_nxt    = dwell;
          line_nxt   = lowest(mask);
        end
      end
      DRIVE: begin
        if (stop) begin
          state_nxt = IDLE;
          line_nxt  = 3'd0;
          cnt_nxt   = 8'd0;
        end else if (cnt == 8'd0) begin
          state_nxt = BLANK;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      BLANK: begin
        if (stop || (single_q && !has_above)) begin
          state_nxt = IDLE;
          line_nxt  = 3'd0;
          cnt_nxt   = 8'd0;
        end else begin
          state_nxt = DRIVE;
          cnt_nxt   = dwell_q;
          line_nxt  = has_above ? above_set : first_set;
        end
      end
      default: begin
        state_nxt = IDLE;
        line_nxt  = 3'd0;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  // Output values are computed one cycle early so the ports come straight from flops.
  always_comb begin
    in_nxt   = (state_nxt == DRIVE);
    busy_nxt = (state_nxt != IDLE);
    done_nxt = ((state != IDLE) && (state_nxt == IDLE)) ||
               ((state == IDLE) && start && !stop && (mask == 8'd0));
  end

  assign a = line[2];
  assign b = line[1];
  assign c = line[0];

endmodule

// File: tb/tb_dec_scan_ctrl.sv
// Scoreboard bench for dec_scan_ctrl: stimulus queues per-cycle expected outputs, a negedge monitor compares.
module tb_dec_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start, stop, single;
  logic [7:0] dwell, mask;
  logic       a, b, c, in, busy, done;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int         cy;
    int         scn;
    logic [5:0] vec;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   lines[5] = '{0, 2, 7, 0, 2};
  int   n0;

  dec_scan_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .single(single),
    .dwell(dwell), .mask(mask), .a(a), .b(b), .c(c), .in(in), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // vec = {in, a, b, c, busy, done}
  task automatic push(input int cy, input int scn, input logic i, input logic [2:0] s,
                      input logic bz, input logic dn);
    exp_t x;
    x.cy  = cy;
    x.scn = scn;
    x.vec = {i, s, bz, dn};
    exp_q.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_now(input string name, input logic [5:0] want);
    n_checks++;
    if ({in, a, b, c, busy, done} !== want) begin
      n_fail++;
      $display("FAIL %s: got {in,abc,busy,done}=%b required %b", name, {in, a, b, c, busy, done}, want);
    end
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cy <= cyc) begin
      e = exp_q.pop_front();
      n_checks++;
      if (e.cy != cyc || {in, a, b, c, busy, done} !== e.vec) begin
        n_fail++;
        $display("FAIL scn%0d cycle %0d: got {in,abc,busy,done}=%b required %b (due cycle %0d)",
                 e.scn, cyc, {in, a, b, c, busy, done}, e.vec, e.cy);
      end
    end
  end

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    stop   = 1'b0;
    single = 1'b0;
    dwell  = 8'd0;
    mask   = 8'd0;
    #1;
    check_now("reset_state", 6'b0);
    repeat (2) step();
    rst_n = 1'b1;
    push(cyc + 1, 0, 0, 3'd0, 0, 0);
    push(cyc + 2, 0, 0, 3'd0, 0, 0);
    repeat (3) step();

    // Scenario 1: full single pass, inputs changed mid-scan must not matter
    n0 = cyc;
    mask = 8'hFF; dwell = 8'd0; single = 1'b1; start = 1'b1;
    for (int k = 0; k < 8; k++) begin
      push(n0 + 1 + 2 * k, 1, 1, 3'(k), 1, 0);
      push(n0 + 2 + 2 * k, 1, 0, 3'(k), 1, 0);
    end
    push(n0 + 17, 1, 0, 3'd0, 0, 1);
    push(n0 + 18, 1, 0, 3'd0, 0, 0);
    step();
    start = 1'b0; mask = 8'h00; dwell = 8'd7; single = 1'b0;
    repeat (19) step();

    // Scenario 2: masked continuous wrap, then stop during a blank
    n0 = cyc;
    mask = 8'b1000_0101; dwell = 8'd2; single = 1'b0; start = 1'b1;
    for (int j = 0; j < 5; j++) begin
      for (int k = 0; k < 3; k++) push(n0 + 1 + 4 * j + k, 2, 1, 3'(lines[j]), 1, 0);
      push(n0 + 4 + 4 * j, 2, 0, 3'(lines[j]), 1, 0);
    end
    push(n0 + 21, 2, 0, 3'd0, 0, 1);
    push(n0 + 22, 2, 0, 3'd0, 0, 0);
    step();
    start = 1'b0;
    repeat (19) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    repeat (2) step();

    // Scenario 3: empty mask
    n0 = cyc;
    mask = 8'h00; dwell = 8'd3; single = 1'b0; start = 1'b1;
    push(n0 + 1, 3, 0, 3'd0, 0, 1);
    push(n0 + 2, 3, 0, 3'd0, 0, 0);
    push(n0 + 3, 3, 0, 3'd0, 0, 0);
    step();
    start = 1'b0;
    repeat (3) step();

    // Scenario 4: stop (with start) in 2nd drive cycle of line 2, then start+stop in idle
    n0 = cyc;
    mask = 8'b0000_0100; dwell = 8'd5; single = 1'b0; start = 1'b1;
    push(n0 + 1, 4, 1, 3'd2, 1, 0);
    push(n0 + 2, 4, 1, 3'd2, 1, 0);
    push(n0 + 3, 4, 0, 3'd0, 0, 1);
    push(n0 + 4, 4, 0, 3'd0, 0, 0);
    push(n0 + 5, 4, 0, 3'd0, 0, 0);
    push(n0 + 6, 4, 0, 3'd0, 0, 0);
    step();
    start = 1'b0;
    step();
    stop = 1'b1; start = 1'b1;
    step();
    stop = 1'b0; start = 1'b0;
    step();
    mask = 8'hFF; stop = 1'b1; start = 1'b1;
    step();
    stop = 1'b0; start = 1'b0;
    repeat (3) step();

    // Scenario 5: async reset mid-drive on line 5, restart at first edge after release (line 4 single)
    n0 = cyc;
    mask = 8'b0010_0000; dwell = 8'd10; single = 1'b0; start = 1'b1;
    push(n0 + 1, 5, 1, 3'd5, 1, 0);
    push(n0 + 2, 5, 1, 3'd5, 1, 0);
    push(n0 + 3, 5, 0, 3'd0, 0, 0);
    push(n0 + 4, 5, 1, 3'd4, 1, 0);
    push(n0 + 5, 5, 0, 3'd4, 1, 0);
    push(n0 + 6, 5, 0, 3'd0, 0, 1);
    push(n0 + 7, 5, 0, 3'd0, 0, 0);
    push(n0 + 8, 5, 0, 3'd0, 0, 0);
    step();
    start = 1'b0;
    repeat (2) step();
    #2;
    rst_n = 1'b0;
    #1;
    check_now("async_reset_drop", 6'b0);
    #2;
    mask = 8'b0001_0000; dwell = 8'd0; single = 1'b1; start = 1'b1;
    #1;
    rst_n = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();

    for (int i = 0; i < 50 && exp_q.size() > 0; i++) step();
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
